// File: rtl/rc_command_decoder.sv
// UART 8N1 command receiver for the RC car: decodes drive characters
// into a one-hot direction code, with a link-loss watchdog.
module rc_command_decoder #(
    parameter int CLK_HZ      = 125_000_000,
    parameter int BAUD        = 9600,
    parameter int TIMEOUT_CYC = 62_500_000
) (
    input  logic       clk_125mhz,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [6:0] direction,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       timeout
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int TW      = $clog2(BIT_CYC + 1);

    localparam logic [TW-1:0] HALF_LD = TW'(BIT_CYC / 2 - 1);
    localparam logic [TW-1:0] FULL_LD = TW'(BIT_CYC - 1);
    localparam logic [26:0]   WD_MAX  = 27'(TIMEOUT_CYC);

    localparam logic [6:0] C_FWD  = 7'b0000001;
    localparam logic [6:0] C_IDLE = 7'b0000010;
    localparam logic [6:0] C_BWD  = 7'b0000100;
    localparam logic [6:0] C_LEFT = 7'b0001000;
    localparam logic [6:0] C_RGT  = 7'b0010000;
    localparam logic [6:0] C_ACC  = 7'b0100000;
    localparam logic [6:0] C_DEC  = 7'b1000000;

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    sync;
    logic          rx_s;
    logic          rx_q;
    logic          fall;
    logic          busy;
    logic          samp;
    logic [TW-1:0] tmr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [6:0]    code;
    logic          known;
    logic          take;
    logic          bad_stop;
    logic [26:0]   wd_cnt;

    assign rx_s = sync[1];
    assign fall = rx_q & ~rx_s;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
            rx_q <= 1'b1;
        end else begin
            sync <= {sync[0], uart_rx};
            rx_q <= rx_s;
        end
    end

    // Receiver state register
    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) state <= S_WAIT_IDLE;
        else          state <= state_nx;
    end

    // Receiver next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_WAIT_IDLE: if (rx_s) state_nx = S_IDLE;
            S_IDLE:      if (fall) state_nx = S_START;
            S_START:     if (samp) state_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (samp && bit_cnt == 3'd7) state_nx = S_STOP;
            S_STOP:      if (samp) state_nx = rx_s ? S_IDLE : S_WAIT_IDLE;
            default:     state_nx = S_WAIT_IDLE;
        endcase
    end

    // Receiver strobes: sample point, accepted command, bad stop bit
    always_comb begin
        busy     = (state == S_START) || (state == S_DATA) ||
                   (state == S_STOP);
        samp     = busy && (tmr == '0);
        take     = (state == S_STOP) && samp && rx_s && known;
        bad_stop = (state == S_STOP) && samp && !rx_s;
    end

    // Character decode of the assembled byte
    always_comb begin
        code  = C_IDLE;
        known = 1'b1;
        case (shreg)
            8'h46, 8'h66: code = C_FWD;
            8'h42, 8'h62: code = C_BWD;
            8'h4C, 8'h6C: code = C_LEFT;
            8'h52, 8'h72: code = C_RGT;
            8'h53, 8'h73: code = C_IDLE;
            8'h2B:        code = C_ACC;
            8'h2D:        code = C_DEC;
            default:      known = 1'b0;
        endcase
    end

    // Bit timer reloads at every sample; data shifts in LSB first
    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            tmr     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (!busy)          tmr <= HALF_LD;
            else if (tmr == '0) tmr <= FULL_LD;
            else                tmr <= tmr - TW'(1);
            if (state == S_START) begin
                bit_cnt <= '0;
            end else if (state == S_DATA && samp) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Output registers and saturating watchdog; a command beats expiry
    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            direction <= C_IDLE;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            cmd_valid <= take;
            frame_err <= bad_stop;
            if (take) begin
                direction <= code;
                wd_cnt    <= '0;
                timeout   <= 1'b0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 27'd1;
                if (wd_cnt + 27'd1 == WD_MAX) begin
                    timeout   <= 1'b1;
                    direction <= C_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rc_command_decoder.sv
// Bench for rc_command_decoder: event-level model of commands and
// watchdog, per-cycle compare, and directed literal checks.
module tb_rc_command_decoder;

    localparam int CLK_HZ = 125_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int TO     = 5000;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int LAT    = 2 + BIT / 2 + 9 * BIT;

    localparam logic [6:0] FWD  = 7'b0000001;
    localparam logic [6:0] IDL  = 7'b0000010;
    localparam logic [6:0] BWD  = 7'b0000100;
    localparam logic [6:0] LFT  = 7'b0001000;
    localparam logic [6:0] RGT  = 7'b0010000;
    localparam logic [6:0] ACC  = 7'b0100000;
    localparam logic [6:0] DEC  = 7'b1000000;

    typedef struct {
        int         cyc;
        int         kind;
        logic [6:0] code;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [6:0] direction;
    logic       cmd_valid;
    logic       frame_err;
    logic       timeout;

    rc_command_decoder #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_125mhz(clk),
        .reset_n(rst_n),
        .uart_rx(uart_rx),
        .direction(direction),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err),
        .timeout(timeout)
    );

    always #4 clk = ~clk;

    int         vectors = 0;
    int         fails = 0;
    int         cyc = 0;
    ev_t        ev_q[$];
    ev_t        ev;
    logic       m_cv = 1'b0;
    logic       m_fe = 1'b0;
    logic [6:0] m_last = IDL;
    int         m_ref = 0;
    logic       exp_to;
    logic [6:0] exp_dir;
    int         cv_cnt = 0;
    int         fe_cnt = 0;
    int         last_cv = -1;
    int         to_rise = -1;
    logic       prev_to = 1'b0;
    int         last_fall = 0;

    function automatic int decode(input logic [7:0] b);
        case (b)
            8'h46, 8'h66: return int'(FWD);
            8'h42, 8'h62: return int'(BWD);
            8'h4C, 8'h6C: return int'(LFT);
            8'h52, 8'h72: return int'(RGT);
            8'h53, 8'h73: return int'(IDL);
            8'h2B:        return int'(ACC);
            8'h2D:        return int'(DEC);
            default:      return -1;
        endcase
    endfunction

    // Model: apply scheduled frame outcomes at their edge
    initial forever begin
        @(posedge clk);
        cyc++;
        m_cv = 1'b0;
        m_fe = 1'b0;
        if (!rst_n) begin
            m_last = IDL;
            m_ref  = cyc;
            ev_q.delete();
        end else if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
            ev = ev_q.pop_front();
            if (ev.kind == 0) begin
                m_cv   = 1'b1;
                m_last = ev.code;
                m_ref  = cyc;
            end else begin
                m_fe = 1'b1;
            end
        end
    end

    // Per-cycle compare and pulse monitor
    initial forever begin
        @(negedge clk);
        exp_to  = rst_n && (cyc - m_ref >= TO);
        exp_dir = exp_to ? IDL : m_last;
        vectors++;
        if (direction !== exp_dir || cmd_valid !== m_cv ||
            frame_err !== m_fe || timeout !== exp_to) begin
            fails++;
            $display("FAIL cycle %0d: dir=%b cv=%b fe=%b to=%b, need dir=%b cv=%b fe=%b to=%b",
                     cyc, direction, cmd_valid, frame_err, timeout,
                     exp_dir, m_cv, m_fe, exp_to);
        end
        if (cmd_valid === 1'b1) begin
            cv_cnt++;
            last_cv = cyc;
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (timeout === 1'b1 && prev_to !== 1'b1) to_rise = cyc;
        prev_to = timeout;
    end

    initial begin
        #(100000 * 8);
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        int d;
        d = decode(b);
        uart_rx   = 1'b0;
        last_fall = cyc + 1;
        if (!stop)
            ev_q.push_back('{last_fall + LAT, 1, 7'd0});
        else if (d >= 0)
            ev_q.push_back('{last_fall + LAT, 0, 7'(d)});
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_timeout(input string name);
        int i;
        for (i = 0; i < TO + 1000; i++) begin
            @(negedge clk);
            #1;
            if (timeout === 1'b1) break;
        end
        check(name, int'(timeout === 1'b1), 1);
    endtask

    int cv0;
    int fe0;
    int ref_r;
    int to0;
    int target;
    int fall_f;

    initial begin
        settle(5);
        rst_n = 1'b1;
        settle(20);

        // Reset in the middle of a frame acts immediately
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (300) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dir", int'(direction), int'(IDL));
        check("async_rst_cv", int'(cmd_valid), 0);
        check("async_rst_fe", int'(frame_err), 0);
        check("async_rst_to", int'(timeout), 0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h46, 1'b1);
        fall_f = last_fall;
        settle(2);
        check("post_rst_F_dir", int'(direction), int'(FWD));
        check("post_rst_F_cv", cv_cnt, 1);
        check("decode_latency", last_cv - fall_f, 1189);

        // Full command set back to back
        cv0 = cv_cnt;
        @(negedge clk);
        send(8'h66, 1'b1);
        send(8'h42, 1'b1);
        send(8'h6C, 1'b1);
        send(8'h52, 1'b1);
        send(8'h73, 1'b1);
        send(8'h2B, 1'b1);
        send(8'h2D, 1'b1);
        settle(5);
        check("set_cv_count", cv_cnt - cv0, 7);
        check("set_last_dir", int'(direction), int'(DEC));

        // Unknown byte and a short glitch
        send(8'h4C, 1'b1);
        cv0 = cv_cnt;
        send(8'h41, 1'b1);
        settle(5);
        check("unknown_dir", int'(direction), int'(LFT));
        check("unknown_cv", cv_cnt - cv0, 0);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        uart_rx = 1'b1;
        settle(200);
        check("glitch_cv", cv_cnt - cv0, 0);
        check("glitch_dir", int'(direction), int'(LFT));

        // Framing error, then a line break
        fe0 = fe_cnt;
        @(negedge clk);
        send(8'h46, 1'b0);
        settle(20);
        check("ferr_count", fe_cnt - fe0, 1);
        check("ferr_dir", int'(direction), int'(LFT));
        @(negedge clk);
        uart_rx = 1'b0;
        ev_q.push_back('{cyc + 1 + LAT, 1, 7'd0});
        repeat (3000) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h42, 1'b1);
        settle(5);
        check("break_fe_count", fe_cnt - fe0, 2);
        check("break_B_dir", int'(direction), int'(BWD));

        // Watchdog expiry, unknown byte does not reload
        @(negedge clk);
        send(8'h46, 1'b1);
        ref_r = last_cv;
        send(8'h00, 1'b1);
        wait_timeout("wd_rise_seen");
        check("wd_onset", to_rise - ref_r, TO);
        check("wd_dir_idle", int'(direction), int'(IDL));
        @(negedge clk);
        send(8'h52, 1'b1);
        settle(2);
        check("wd_clear_to", int'(timeout), 0);
        check("wd_R_dir", int'(direction), int'(RGT));

        // Command landing exactly on the expiry cycle
        ref_r  = m_ref;
        to0    = to_rise;
        target = ref_r + TO - LAT - 1;
        for (int g = 0; g < 2 * TO && cyc < target; g++)
            @(negedge clk);
        check("align_reached", int'(cyc == target), 1);
        send(8'h42, 1'b1);
        settle(2);
        check("sim_cv_cycle", last_cv - ref_r, TO);
        check("sim_dir", int'(direction), int'(BWD));
        check("sim_no_to", to_rise, to0);
        wait_timeout("sim_restart_seen");
        check("sim_restart", to_rise - last_cv, TO);

        settle(5);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, fails);
        $finish;
    end

endmodule
